alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
Execute stage fed by the ALU-source mux. Operand A comes from register-file read port 1; operand B is the mux output (register Rd2 or instruction immediate). Performs 4-bit arithmetic, logic and shift ops with a registered result and flags. An optional iterative shift-and-add multiplier runs multi-cycle behind a start/busy/done handshake.

Parameters:
DATA_W, 4, operand/result width (only 4 supported; parameter documents the width)
MUL_CYCLES, 4, multiplier iterations; must equal DATA_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  operation request; sampled only when busy=0
alu_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
operand_a  in  4  register-file Rd1 data
operand_b  in  4  ALU-source mux output
busy  out  1  multiply in progress
done  out  1  one-cycle pulse: result and flags updated
result  out  4  result; low nibble of the product for MUL
result_hi  out  4  product high nibble
flag_z  out  1  zero
flag_c  out  1  carry/borrow/shift-out
flag_n  out  1  result[3]
flag_v  out  1  signed overflow

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, result_hi=0, all flags=0. Reset mid-multiply abandons it and produces no done.
- FSM states: IDLE, MUL.
- IDLE with start=1 and op≠111: at the edge, result and flags update, done=1 for one cycle, state stays IDLE.
  - Latency is 1 cycle.
  - Back-to-back starts give a done every cycle.
  - result_hi is cleared to 0 on non-MUL ops.
- IDLE with start=1 and op=111: at the edge, latch operands, clear the accumulator, cnt=0, state goes to MUL, busy=1.
- MUL: each edge adds (b[cnt] ? a<<cnt : 0) into an 8-bit accumulator and increments cnt.
  - On the edge where cnt=3: {result_hi,result}=product, flags update, done=1, state goes to IDLE, busy=0.
  - Start-to-done latency is 5 cycles; busy is high for 4 cycles.
- start while busy=1 is ignored, with no queueing. Operands need only be valid in the start cycle.
- done and busy are never high together.
- When no operation completes, result and flags hold their values.
- Arithmetic (4-bit wraps):
  - ADD: C=carry-out; V=(a[3]==b[3])&&(r[3]!=a[3]).
  - SUB: r=a-b; C=borrow (a<b unsigned); V=(a[3]!=b[3])&&(r[3]!=a[3]).
  - AND/OR/XOR: C=0, V=0.
  - SHL/SHR: shift amount=b[1:0], zero fill. C=last bit shifted out; C=0 when the amount is 0. V=0.
  - MUL (unsigned): C=(product[7:4]≠0); Z=(8-bit product==0); N=result[3]; V=0.
- Z on all non-MUL ops is (result==0).

Optional Feature:
ALU_MUL_EN
- Defined: MUL path, MUL state and result_hi behave as above.
- Undefined: op 111 completes in 1 cycle with done=1; result, result_hi and flags hold. busy is tied 0, result_hi is tied 0, and the FSM and multiplier logic are removed.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD..OP_MUL), FSM state encoding, DATA_W constant.
- Sub-module alu_shift_add_mul: multiplier datapath (operand latch, 8-bit accumulator, 2-bit cnt, last-iteration indicator). Instantiated only under ALU_MUL_EN.
- The top level holds the combinational single-cycle ops, flag logic and the FSM.

Test Plan:
- Reset, then ADD a=9 b=8 with start -> next cycle: done=1, result=1, C=1, V=1, Z=0, N=0. Following cycle: done=0, values held.
- SUB a=3 b=5 -> result=0xE, C=1, N=1, V=0. Then back-to-back XOR a=5 b=5 next cycle -> done on consecutive cycles, result=0, Z=1.
- SHL a=0x9 b=1 -> result=0x2, C=1. Then SHR a=0x9 b=0 -> result=0x9, C=0.
- (ALU_MUL_EN) MUL a=0xF b=0xF:
  - busy=1 for 4 cycles, then done=1 5 cycles after start, with result=0x1, result_hi=0xE, C=1, Z=0.
  - start with ADD during busy -> ignored; no extra done.
- (ALU_MUL_EN) MUL a=3 b=2, rst_n pulsed low during the 2nd busy cycle -> all outputs 0 immediately, busy=0, no done. A subsequent ADD 1+1 returns 2.
- (no ALU_MUL_EN) After ADD 1+1, issue op 111 -> done next cycle, result=2 held, busy stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and datapath width for alu_exec_unit
package alu_pkg;
  localparam int DATA_W = 4;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;
  typedef enum logic {IDLE, MUL} state_t;
endpackage

// File: rtl/alu_shift_add_mul.sv
// alu_shift_add_mul: iterative shift-and-add multiplier datapath, one partial product per cycle
module alu_shift_add_mul #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [2*W-1:0]   product,
  output logic             last
);
  logic [W-1:0] a_q, b_q;
  logic [2*W-1:0] acc;
  logic [$clog2(N)-1:0] cnt;
  // product is the accumulator after this cycle's partial product, so the final sum is ready on the last edge
  assign product = acc + (b_q[cnt] ? {{W{1'b0}}, a_q} << cnt : '0);
  assign last = cnt == ($clog2(N))'(N - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      a_q <= a;
      b_q <= b;
      acc <= '0;
      cnt <= '0;
    end else if (step) begin
      acc <= product;
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: 4-bit execute stage with registered result/flags; ALU_MUL_EN adds a multi-cycle multiplier
module alu_exec_unit #(
  parameter int DATA_W     = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] result_hi,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_n,
  output logic              flag_v
);
  import alu_pkg::*;
  if (DATA_W != 4 || MUL_CYCLES != DATA_W) begin : g_bad_cfg
    $error("alu_exec_unit supports only DATA_W=4 with MUL_CYCLES=DATA_W");
  end
  logic [DATA_W:0] sum, diff, shl, shr;
  logic [DATA_W-1:0] alu_r;
  logic alu_c, alu_v, alu_fire, done_d, mul_fin;
  logic [2*DATA_W-1:0] product;
  assign sum  = {1'b0, operand_a} + {1'b0, operand_b};
  assign diff = {1'b0, operand_a} - {1'b0, operand_b};
  assign shl  = {1'b0, operand_a} << operand_b[1:0];
  // the extra low bit catches the last bit shifted out to the right
  assign shr  = {operand_a, 1'b0} >> operand_b[1:0];
  always_comb begin
    alu_r = alu_op == OP_ADD ? sum[DATA_W-1:0] :
            alu_op == OP_SUB ? diff[DATA_W-1:0] :
            alu_op == OP_AND ? operand_a & operand_b :
            alu_op == OP_OR  ? operand_a | operand_b :
            alu_op == OP_XOR ? operand_a ^ operand_b :
            alu_op == OP_SHL ? shl[DATA_W-1:0] : shr[DATA_W:1];
    alu_c = alu_op == OP_ADD ? sum[DATA_W] :
            alu_op == OP_SUB ? diff[DATA_W] :
            alu_op == OP_SHL ? shl[DATA_W] :
            alu_op == OP_SHR ? shr[0] : 1'b0;
    alu_v = alu_op == OP_ADD ? (operand_a[3] == operand_b[3]) && (sum[3] != operand_a[3]) :
            alu_op == OP_SUB ? (operand_a[3] != operand_b[3]) && (diff[3] != operand_a[3]) : 1'b0;
  end
`ifdef ALU_MUL_EN
  state_t state, state_d;
  logic mul_last;
  assign busy     = state == MUL;
  assign alu_fire = start && !busy && alu_op != OP_MUL;
  assign mul_fin  = busy && mul_last;
  assign done_d   = alu_fire || mul_fin;
  always_comb begin
    state_d = state;
    state_d = state == IDLE ? (start && alu_op == OP_MUL ? MUL : IDLE) : (mul_last ? IDLE : MUL);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  alu_shift_add_mul #(.W(DATA_W), .N(MUL_CYCLES)) u_mul (
    .clk(clk), .rst_n(rst_n),
    .load(start && !busy && alu_op == OP_MUL), .step(busy),
    .a(operand_a), .b(operand_b),
    .product(product), .last(mul_last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) result_hi <= '0;
    else if (alu_fire) result_hi <= '0;
    else if (mul_fin) result_hi <= product[2*DATA_W-1:DATA_W];
`else
  assign busy      = 1'b0;
  assign result_hi = '0;
  assign alu_fire  = start && alu_op != OP_MUL;
  assign mul_fin   = 1'b0;
  assign product   = '0;
  assign done_d    = start;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      done   <= 1'b0;
      result <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      done <= done_d;
      if (alu_fire) begin
        result <= alu_r;
        flag_z <= alu_r == '0;
        flag_c <= alu_c;
        flag_n <= alu_r[DATA_W-1];
        flag_v <= alu_v;
      end else if (mul_fin) begin
        result <= product[DATA_W-1:0];
        flag_z <= product == '0;
        flag_c <= |product[2*DATA_W-1:DATA_W];
        flag_n <= product[DATA_W-1];
        flag_v <= 1'b0;
      end
    end
endmodule
